// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - multi-channel LED pattern generator on one shared prescaled counter
// Each channel runs OFF/ON/BLINK/PWM/BURST, configured through a valid/ready write port.
module led_pattern_ctrl #(
   parameter int CHANNELS   = 2,
   parameter int CNT_WIDTH  = 28,
   parameter int PRESCALE   = 1,
   parameter int DUTY_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [3:0]            cfg_chan,
   input  logic [2:0]            cfg_mode,
   input  logic [4:0]            cfg_sel,
   input  logic [DUTY_WIDTH-1:0] cfg_duty,
   output logic [CHANNELS-1:0]   LED,
   output logic [CHANNELS-1:0]   done,
   output logic                  cfg_err,
   output logic [CNT_WIDTH-1:0]  count
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0]       PS_MAX     = PS_W'(PRESCALE - 1);
   localparam logic [5:0]            SEL_LIMIT  = 6'(CNT_WIDTH);
   localparam logic [4:0]            SEL_MAX    = 5'(CNT_WIDTH - 1);
   localparam logic [4:0]            CHAN_LIMIT = 5'(CHANNELS);
   localparam logic [DUTY_WIDTH-1:0] DUTY_ONE   = DUTY_WIDTH'(1);

   localparam logic [2:0] MODE_OFF   = 3'd0;
   localparam logic [2:0] MODE_ON    = 3'd1;
   localparam logic [2:0] MODE_BLINK = 3'd2;
   localparam logic [2:0] MODE_PWM   = 3'd3;
   localparam logic [2:0] MODE_BURST = 3'd4;

   localparam logic [1:0] B_IDLE = 2'd0;
   localparam logic [1:0] B_WAIT = 2'd1;
   localparam logic [1:0] B_RUN  = 2'd2;

   logic [PS_W-1:0]       presc_q, presc_d;
   logic                  en;
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic [31:0]           cnt_cur, cnt_nxt;
   logic                  ready_q, ready_d;
   logic                  err_q, err_d;
   logic                  wr, chan_ok;
   logic [2:0]            wr_mode;
   logic [4:0]            wr_sel;

   logic [2:0]            mode_q [CHANNELS];
   logic [2:0]            mode_d [CHANNELS];
   logic [4:0]            sel_q  [CHANNELS];
   logic [4:0]            sel_d  [CHANNELS];
   logic [DUTY_WIDTH-1:0] duty_q [CHANNELS];
   logic [DUTY_WIDTH-1:0] duty_d [CHANNELS];
   logic [DUTY_WIDTH-1:0] rem_q  [CHANNELS];
   logic [DUTY_WIDTH-1:0] rem_d  [CHANNELS];
   logic [1:0]            bst_q  [CHANNELS];
   logic [1:0]            bst_d  [CHANNELS];

   logic [CHANNELS-1:0]   bit_cur, bit_nxt;
   logic [CHANNELS-1:0]   led_q, led_d;
   logic [CHANNELS-1:0]   done_q, done_d;

   // Edges of count[sel] are seen by comparing the current value with the post-increment value.
   always_comb begin
      en      = (presc_q == PS_MAX);
      presc_d = en ? '0 : presc_q + PS_W'(1);
      count_d = en ? count_q + CNT_WIDTH'(1) : count_q;
      cnt_cur = 32'(count_q);
      cnt_nxt = 32'(count_d);
   end

   always_comb begin
      wr      = cfg_valid & ready_q;
      chan_ok = ({1'b0, cfg_chan} < CHAN_LIMIT);
      wr_mode = (cfg_mode > MODE_BURST) ? MODE_OFF : cfg_mode;
      wr_sel  = ({1'b0, cfg_sel} >= SEL_LIMIT) ? SEL_MAX : cfg_sel;
      err_d   = wr & ~chan_ok;
      ready_d = 1'b1;
   end

   always_comb begin
      led_d   = '0;
      done_d  = '0;
      bit_cur = '0;
      bit_nxt = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         mode_d[i]  = mode_q[i];
         sel_d[i]   = sel_q[i];
         duty_d[i]  = duty_q[i];
         rem_d[i]   = rem_q[i];
         bst_d[i]   = bst_q[i];
         bit_cur[i] = cnt_cur[sel_q[i]];
         bit_nxt[i] = cnt_nxt[sel_q[i]];

         case (mode_q[i])
            MODE_ON:    led_d[i] = 1'b1;
            MODE_BLINK: led_d[i] = bit_cur[i];
            MODE_PWM:   led_d[i] = (count_q[DUTY_WIDTH-1:0] < duty_q[i]);
            MODE_BURST: begin
               led_d[i] = (bst_q[i] == B_RUN) & bit_cur[i];
               case (bst_q[i])
                  B_WAIT: begin
                     if (en && !bit_cur[i] && bit_nxt[i]) begin
                        bst_d[i] = B_RUN;
                     end
                  end
                  B_RUN: begin
                     if (en && bit_cur[i] && !bit_nxt[i]) begin
                        if (rem_q[i] == DUTY_ONE) begin
                           bst_d[i]  = B_IDLE;
                           mode_d[i] = MODE_OFF;
                           rem_d[i]  = '0;
                           done_d[i] = 1'b1;
                        end else begin
                           rem_d[i] = rem_q[i] - DUTY_ONE;
                        end
                     end
                  end
                  default: begin
                     bst_d[i]  = B_IDLE;
                     mode_d[i] = MODE_OFF;
                  end
               endcase
            end
            default: led_d[i] = 1'b0;
         endcase

         // A write always wins over an in-flight burst, including its completion.
         if (wr && (cfg_chan == 4'(i))) begin
            sel_d[i]  = wr_sel;
            duty_d[i] = cfg_duty;
            done_d[i] = 1'b0;
            if (wr_mode == MODE_BURST) begin
               if (cfg_duty == '0) begin
                  mode_d[i] = MODE_OFF;
                  bst_d[i]  = B_IDLE;
                  rem_d[i]  = '0;
                  done_d[i] = 1'b1;
               end else begin
                  mode_d[i] = MODE_BURST;
                  bst_d[i]  = B_WAIT;
                  rem_d[i]  = cfg_duty;
               end
            end else begin
               mode_d[i] = wr_mode;
               bst_d[i]  = B_IDLE;
               rem_d[i]  = '0;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         presc_q <= '0;
         count_q <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         led_q   <= '0;
         done_q  <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            mode_q[i] <= MODE_OFF;
            sel_q[i]  <= '0;
            duty_q[i] <= '0;
            rem_q[i]  <= '0;
            bst_q[i]  <= B_IDLE;
         end
      end else begin
         presc_q <= presc_d;
         count_q <= count_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         led_q   <= led_d;
         done_q  <= done_d;
         for (int i = 0; i < CHANNELS; i++) begin
            mode_q[i] <= mode_d[i];
            sel_q[i]  <= sel_d[i];
            duty_q[i] <= duty_d[i];
            rem_q[i]  <= rem_d[i];
            bst_q[i]  <= bst_d[i];
         end
      end
   end

   assign cfg_ready = ready_q;
   assign cfg_err   = err_q;
   assign LED       = led_q;
   assign done      = done_q;
   assign count     = count_q;

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
Parametrised multi-channel LED pattern generator, the successor to the single free-running-counter blinker. One shared prescaled counter drives CHANNELS independent LED outputs. Each channel is configured at run time over a valid/ready write port to one of five modes: OFF, ON, BLINK, PWM, or counted BURST with completion pulse. Sits between board-level control logic and the LED pins.

Parameters:
CHANNELS, 2, number of LED outputs (1..16)
CNT_WIDTH, 28, shared counter width (8..32)
PRESCALE, 1, clocks per counter increment (>=1)
DUTY_WIDTH, 8, PWM duty and burst-count width (<= CNT_WIDTH)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
cfg_valid  in  1  config write request
cfg_ready  out  1  config port can accept
cfg_chan  in  4  target channel index
cfg_mode  in  3  0 OFF, 1 ON, 2 BLINK, 3 PWM, 4 BURST; 5-7 are treated as OFF
cfg_sel  in  5  counter bit index for BLINK/BURST rate
cfg_duty  in  DUTY_WIDTH  PWM threshold or BURST pulse count
LED  out  CHANNELS  registered LED drive
done  out  CHANNELS  one-cycle pulse at BURST completion
cfg_err  out  1  one-cycle pulse when cfg_chan >= CHANNELS
count  out  CNT_WIDTH  shared counter value (debug)

Behaviour:
- Single clock; reset is synchronous and active-high.
- Reset clears all state: prescaler=0, count=0, every channel mode=OFF with sel=0, duty=0, remaining=0, LED=0, done=0, cfg_err=0, cfg_ready=0.
- cfg_ready is registered: 0 during any reset cycle, 1 from the first clock after reset deasserts.
- Prescaler counts 0..PRESCALE-1. The enable pulse en fires in the cycle the prescaler equals PRESCALE-1; with PRESCALE=1, en is high every cycle.
- count increments by 1 on en and wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- A write is accepted on an edge where cfg_valid && cfg_ready. Channel registers update at that edge, and LED reflects the new mode from the following edge (1-cycle latency).
- On accept with cfg_chan >= CHANNELS: no channel changes; cfg_err pulses on the next cycle.
- cfg_sel >= CNT_WIDTH is clamped to CNT_WIDTH-1 at write time.
- A rewrite of a channel in any mode, including mid-BURST, replaces its config immediately. No done pulse is produced, and remaining reloads.
- LED[i], registered each cycle from the current mode:
  - OFF: 0.
  - ON: 1.
  - BLINK: count[sel].
  - PWM: (count[DUTY_WIDTH-1:0] < duty), unsigned. duty=0 gives constant 0; duty=2^DUTY_WIDTH-1 gives high for 255/256 of the period.
  - BURST: see the state machine below.
- BURST per-channel state machine (IDLE, WAIT, RUN):
  - Accept of BURST with duty>0: remaining=duty, state=WAIT.
  - Accept of BURST with duty=0: mode becomes OFF and done[i] pulses on the next cycle.
  - WAIT: LED=0 until an en cycle in which count[sel] goes 0->1, then state=RUN.
  - RUN: LED=count[sel]. On each en where count[sel] goes 1->0, remaining decrements.
  - When remaining reaches 0: state=IDLE, mode=OFF, LED=0, and done[i]=1 for exactly one cycle.
- Channels are fully independent. Simultaneous completions on several channels each pulse their own done bit.
- Reset asserted mid-operation aborts everything with no done pulses. The counter restarts at 0.

Test Plan:
1. Reset for 3 cycles with CNT_WIDTH=8, PRESCALE=1 -> LED=00, done=00, cfg_ready=0 during reset, 1 on the first cycle after, count=0,1,2... from release.
2. Write ch0 BLINK sel=2, PRESCALE=1 -> LED[0] has period 8 clocks, 4 high / 4 low, tracking count[2] one cycle late. Repeat with PRESCALE=4 -> period 32 clocks.
3. Write ch1 PWM duty=64, DUTY_WIDTH=8 -> exactly 64 high clocks per 256-clock window. Then duty=0 -> LED[1] constant 0. Then duty=255 -> exactly 255 high clocks per 256.
4. Write ch0 BURST sel=1 duty=3 -> three 2-clock high pulses, then LED[0]=0, a single-cycle done[0], and mode OFF; LED[1] unaffected.
5. Write cfg_chan=2 with CHANNELS=2 -> cfg_err pulses once, LEDs unchanged. Write sel=31 with CNT_WIDTH=8 -> behaves as sel=7.
6. Assert reset after the second BURST pulse -> LED=0, no done pulse, and count=0 after release. A rewrite mid-BURST to ON -> LED=1 with no done pulse.
